conbus_rr: RTL and testbench

- Parametrised Wishbone shared-bus interconnect with NM masters and NS slaves. Successor to the fixed 6x6 priority interconnect.
- Adds fair round-robin arbitration and per-slave address decode taken from a flattened parameter.
- Adds ack/data return from the selected slave only, plus bus-error termination (err_o) for unmapped addresses and slave time-outs.
- Sits between CPU/DMA masters and peripheral/memory slaves at the top of the system.

---
 rtl/conbus_rr_if.sv | 27 ++
 rtl/conbus_rr.sv | 132 +++++++++++++
 tb/tb_conbus_rr.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/conbus_rr_if.sv
// Signal bundle for conbus_rr: NM Wishbone master ports and NS slave ports.
// The "slave" modport is the interconnect's view; "master" is the attached-agent view.
interface conbus_rr_if #(
   parameter int NM = 6,
   parameter int NS = 6
);
   logic [NM-1:0][31:0] m_dat_i, m_dat_o, m_adr_i;
   logic [NM-1:0][2:0]  m_cti_i;
   logic [NM-1:0][3:0]  m_sel_i;
   logic [NM-1:0]       m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o;
   logic [NS-1:0][31:0] s_dat_i, s_dat_o, s_adr_o;
   logic [NS-1:0][2:0]  s_cti_o;
   logic [NS-1:0][3:0]  s_sel_o;
   logic [NS-1:0]       s_we_o, s_cyc_o, s_stb_o, s_ack_i;

   modport slave (
      input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o,
             s_stb_o
   );

   modport master (
      output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o,
             s_stb_o
   );
endinterface

// File: rtl/conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration, parameterised
// slave decode, and bus-error termination for unmapped addresses and slave time-outs.
module conbus_rr_match #(
   parameter int W = 4
) (
   input  logic [W-1:0] adr_hi,
   input  logic [W-1:0] base,
   output logic         match
);
   assign match = (adr_hi == base);
endmodule

module conbus_rr #(
   parameter int                     NM        = 6,
   parameter int                     NS        = 6,
   parameter int                     S_ADDR_W  = 4,
   parameter logic [NS*S_ADDR_W-1:0] S_ADDR    = 24'h543210,
   parameter int                     TIMEOUT_W = 8,
   parameter int                     TIMEOUT   = 255
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   conbus_rr_if.slave bus
);
   localparam int PTR_W = (NM > 1) ? $clog2(NM) : 1;
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [NM-1:0]        gnt, gnt_nxt;
   logic [PTR_W-1:0]     ptr, ptr_nxt, cand;
   logic                 found;
   logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
   logic                 err_q, err_nxt;

   logic [31:0]   adr, wdat, rdat;
   logic [2:0]    cti;
   logic [3:0]    sel;
   logic          we, cyc, stb, req, hit, ack_sel, to_fire;
   logic [NS-1:0] match, sel_oh;

   // Owner keeps the bus while cyc is high; otherwise search starts just past the last winner.
   always_comb begin
      gnt_nxt = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      cand    = '0;
      if (|(gnt & bus.m_cyc_i)) begin
         gnt_nxt = gnt;
      end else begin
         for (int k = 1; k <= NM; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NM);
            if (!found && bus.m_cyc_i[cand]) begin
               found         = 1'b1;
               gnt_nxt[cand] = 1'b1;
               ptr_nxt       = cand;
            end
         end
      end
   end

   always_comb begin
      adr  = '0;
      wdat = '0;
      cti  = '0;
      sel  = '0;
      we   = 1'b0;
      cyc  = 1'b0;
      stb  = 1'b0;
      for (int i = 0; i < NM; i++) begin
         adr  = adr  | ({32{gnt[i]}} & bus.m_adr_i[i]);
         wdat = wdat | ({32{gnt[i]}} & bus.m_dat_i[i]);
         cti  = cti  | ({3{gnt[i]}}  & bus.m_cti_i[i]);
         sel  = sel  | ({4{gnt[i]}}  & bus.m_sel_i[i]);
         we   = we   | (gnt[i] & bus.m_we_i[i]);
         cyc  = cyc  | (gnt[i] & bus.m_cyc_i[i]);
         stb  = stb  | (gnt[i] & bus.m_stb_i[i]);
      end
   end

   for (genvar k = 0; k < NS; k++) begin : g_dec
      conbus_rr_match #(.W(S_ADDR_W)) u_match (
         .adr_hi (adr[31 -: S_ADDR_W]),
         .base   (S_ADDR[k*S_ADDR_W +: S_ADDR_W]),
         .match  (match[k])
      );
   end

   // Lowest matching slave index wins when decode ranges overlap.
   assign sel_oh  = match & (~match + NS'(1));
   assign hit     = |match;
   assign ack_sel = |(sel_oh & bus.s_ack_i);
   assign req     = cyc & stb;

   always_comb begin
      rdat = '0;
      for (int k = 0; k < NS; k++) rdat = rdat | ({32{sel_oh[k]}} & bus.s_dat_i[k]);
   end

   // A coinciding ack suppresses the time-out; err_q always has a quiet cycle after it.
   assign to_fire = (TIMEOUT != 0) && req && hit && !ack_sel && (wdog == TO_LAST);
   assign err_nxt = !err_q && req && (!hit || to_fire);

   always_comb begin
      wdog_nxt = wdog;
      if (ack_sel || !req || (gnt_nxt != gnt) || err_q) wdog_nxt = '0;
      else if (hit && (wdog != '1))                      wdog_nxt = wdog + 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         gnt   <= '0;
         ptr   <= PTR_W'(NM - 1);
         wdog  <= '0;
         err_q <= 1'b0;
      end else begin
         gnt   <= gnt_nxt;
         ptr   <= ptr_nxt;
         wdog  <= wdog_nxt;
         err_q <= err_nxt;
      end
   end

   assign bus.m_dat_o = {NM{rdat}};
   assign bus.m_ack_o = gnt & {NM{ack_sel & ~err_q}};
   assign bus.m_err_o = gnt & {NM{err_q}};
   assign bus.s_dat_o = {NS{wdat}};
   assign bus.s_adr_o = {NS{adr}};
   assign bus.s_cti_o = {NS{cti}};
   assign bus.s_sel_o = {NS{sel}};
   assign bus.s_we_o  = {NS{we}};
   assign bus.s_cyc_o = {NS{cyc}};
   assign bus.s_stb_o = sel_oh & {NS{req & ~err_q}};
endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr: reset, round-robin order, burst hold, unmapped error,
// watchdog time-out with ack priority, selective ack, and mid-transfer reset.
module tb_conbus_rr;
   localparam int NM = 6;
   localparam int NS = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   beats = 0;
   int   rr_exp [6] = '{1, 2, 4, 1, 2, 4};

   always #5 clk = ~clk;

   conbus_rr_if #(.NM(NM), .NS(NS)) bus ();

   conbus_rr #(
      .NM(NM), .NS(NS), .S_ADDR_W(4), .S_ADDR(24'h543210), .TIMEOUT_W(8), .TIMEOUT(16)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.m_dat_i = '0;
      bus.m_adr_i = '0;
      bus.m_cti_i = '0;
      bus.m_sel_i = '0;
      bus.m_we_i  = '0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.s_ack_i = '0;
      for (int k = 0; k < NS; k++) bus.s_dat_i[k] = 32'hA0A0_0000 + k;
      for (int i = 0; i < NM; i++) bus.m_adr_i[i] = 32'h1000_0000 + i;

      // reset held 3 cycles with every master requesting and every slave acking
      bus.m_cyc_i = '1;
      bus.m_stb_i = '1;
      bus.s_ack_i = '1;
      repeat (3) step();
      #2;
      chk("rst_stb", bus.s_stb_o, 0);
      chk("rst_cyc", bus.s_cyc_o, 0);
      chk("rst_ack", bus.m_ack_o, 0);
      chk("rst_err", bus.m_err_o, 0);
      chk("rst_adr", bus.s_adr_o[0], 0);
      rst_n = 1'b1;
      #1;
      chk("rel_idle", bus.s_cyc_o, 0);
      step(); #2;
      chk("first_adr", bus.s_adr_o[0], 32'h1000_0000);
      chk("first_ack", bus.m_ack_o, 6'b000001);
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.s_ack_i = '0;

      // round robin among masters 1,2,4; the served master rests one cycle
      bus.s_ack_i = 6'b000010;
      bus.m_cyc_i = 6'b010110;
      bus.m_stb_i = 6'b010110;
      for (int j = 0; j < 6; j++) begin
         step(); #2;
         chk("rr_adr", bus.s_adr_o[0], 32'h1000_0000 + rr_exp[j]);
         chk("rr_ack", bus.m_ack_o, 32'(1) << rr_exp[j]);
         bus.m_cyc_i = 6'b010110 & ~(6'(1) << rr_exp[j]);
         bus.m_stb_i = bus.m_cyc_i;
      end
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      step(); #2;
      chk("idle_cyc", bus.s_cyc_o, 0);

      // 4-beat burst from master 0 with an idle stb gap while master 3 waits
      bus.m_adr_i[0] = 32'h2000_0000;
      bus.m_cti_i[0] = 3'b010;
      bus.m_dat_i[0] = 32'hCAFE_0000;
      bus.m_adr_i[3] = 32'h3000_0003;
      bus.m_cyc_i    = 6'b001001;
      bus.m_stb_i    = 6'b001001;
      bus.s_ack_i    = 6'b000100;
      for (int b = 0; b < 5; b++) begin
         step();
         bus.m_stb_i[0] = (b != 2);
         bus.s_ack_i    = (b == 2) ? 6'b000000 : 6'b000100;
         #2;
         chk("burst_adr", bus.s_adr_o[0], 32'h2000_0000);
         chk("burst_stb", bus.s_stb_o, (b == 2) ? 6'b000000 : 6'b000100);
         chk("burst_ack", bus.m_ack_o, (b == 2) ? 6'b000000 : 6'b000001);
         chk("burst_cti", bus.s_cti_o[2], 3'b010);
         if (bus.s_stb_o[2]) beats++;
      end
      chk("burst_beats", beats, 4);
      chk("burst_wdat", bus.s_dat_o[5], 32'hCAFE_0000);
      bus.m_cyc_i[0] = 1'b0;
      bus.m_stb_i[0] = 1'b0;
      step(); #2;
      chk("hand_adr", bus.s_adr_o[0], 32'h3000_0003);
      chk("hand_stb", bus.s_stb_o, 6'b001000);
      chk("hand_ack", bus.m_ack_o, 0);
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      step();

      // unmapped read from master 1 held for two error cycles
      bus.s_ack_i    = '1;
      bus.m_adr_i[1] = 32'hF000_0000;
      bus.m_cyc_i    = 6'b000010;
      bus.m_stb_i    = 6'b000010;
      for (int c = 1; c <= 5; c++) begin
         step(); #2;
         chk("unm_err", bus.m_err_o, (c == 2 || c == 4) ? 6'b000010 : 6'b000000);
         chk("unm_stb", bus.s_stb_o, 0);
         chk("unm_ack", bus.m_ack_o, 0);
         if (c <= 4) chk("unm_dat", bus.m_dat_o[1], 0);
         if (c == 4) begin
            bus.m_cyc_i = '0;
            bus.m_stb_i = '0;
         end
      end

      // master 2 to a silent slave 3: two time-outs, then an ack on the firing cycle
      bus.s_ack_i    = '0;
      bus.m_adr_i[2] = 32'h3000_0004;
      bus.m_cyc_i    = 6'b000100;
      bus.m_stb_i    = 6'b000100;
      for (int c = 1; c <= 52; c++) begin
         step();
         bus.s_ack_i = (c == 50) ? 6'b001000 : 6'b000000;
         #2;
         chk("to_err", bus.m_err_o, (c == 17 || c == 34) ? 6'b000100 : 6'b000000);
         chk("to_stb", bus.s_stb_o, (c == 17 || c == 34) ? 6'b000000 : 6'b001000);
         chk("to_ack", bus.m_ack_o, (c == 50) ? 6'b000100 : 6'b000000);
      end
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      step();

      // only the selected slave's ack and data reach the master
      bus.m_adr_i[0] = 32'h1000_0010;
      bus.m_cti_i[0] = 3'b000;
      bus.s_dat_i[1] = 32'hDEAD_BEEF;
      bus.s_dat_i[4] = 32'h1111_1111;
      bus.s_ack_i    = 6'b010000;
      bus.m_cyc_i    = 6'b000001;
      bus.m_stb_i    = 6'b000001;
      step(); #2;
      chk("sel_noack", bus.m_ack_o, 0);
      chk("sel_stb", bus.s_stb_o, 6'b000010);
      chk("sel_dat", bus.m_dat_o[0], 32'hDEAD_BEEF);
      bus.s_ack_i = 6'b010010;
      #1;
      chk("sel_ack", bus.m_ack_o, 6'b000001);
      chk("sel_dat_bc", bus.m_dat_o[3], 32'hDEAD_BEEF);

      // reset while master 0 still owns the bus
      bus.s_ack_i = '0;
      rst_n = 1'b0;
      step(); #2;
      chk("mrst_stb", bus.s_stb_o, 0);
      chk("mrst_cyc", bus.s_cyc_o, 0);
      rst_n = 1'b1;
      step(); #2;
      chk("mrst_regnt", bus.s_stb_o, 6'b000010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
